// File: rtl/switch_pkg.sv
// switch_pkg: types and field positions shared across the packet switch
package switch_pkg;
  typedef logic [1:0] port_idx_t;
  typedef enum logic [1:0] {S_EMPTY, S_REQ, S_WAIT, S_HELD} in_state_t;
  localparam int WORD_W = 32;
  localparam int DST_W = 2;
  localparam int DST_MSB_DEF = 31;
  localparam port_idx_t DST_DROP = 2'd0;
  function automatic port_idx_t wrap3(port_idx_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction
  function automatic port_idx_t oh_to_sel(logic [2:0] oh);
    return oh[0] ? 2'd1 : oh[1] ? 2'd2 : oh[2] ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/ingress_arbiter_if.sv
// ingress_arbiter_if: FIFO read side and output port handshake of the ingress arbiter
interface ingress_arbiter_if #(parameter int CNT_W = 16);
  import switch_pkg::*;
  logic [2:0] fifo_empty;
  logic [WORD_W-1:0] fifo_q1;
  logic [WORD_W-1:0] fifo_q2;
  logic [WORD_W-1:0] fifo_q3;
  logic [2:0] fifo_rdreq;
  logic [2:0] out_ready;
  logic [2:0] out_valid;
  logic [WORD_W-1:0] out_data1;
  logic [WORD_W-1:0] out_data2;
  logic [WORD_W-1:0] out_data3;
  port_idx_t sel1;
  port_idx_t sel2;
  port_idx_t sel3;
  logic [CNT_W-1:0] drop_count;
  modport master (
    input fifo_empty, fifo_q1, fifo_q2, fifo_q3, out_ready,
    output fifo_rdreq, out_valid, out_data1, out_data2, out_data3, sel1, sel2, sel3, drop_count
  );
  modport slave (
    output fifo_empty, fifo_q1, fifo_q2, fifo_q3, out_ready,
    input fifo_rdreq, out_valid, out_data1, out_data2, out_data3, sel1, sel2, sel3, drop_count
  );
endinterface

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-request round-robin arbiter, priority starts after the last grant
module rr_arbiter3 import switch_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_i,
  input  logic       en_i,
  output logic [2:0] gnt_o
);
  port_idx_t last_q, last_d;
  port_idx_t p0, p1, p2, win;
  logic      hit;
  // search order begins at the input following the last winner; last is 1-based
  always_comb begin
    p0 = (last_q == 2'd3) ? 2'd0 : last_q;
    p1 = wrap3(p0);
    p2 = wrap3(p1);
    hit = en_i && |req_i;
    win = req_i[p0] ? p0 : req_i[p1] ? p1 : p2;
    gnt_o = hit ? (3'b001 << win) : 3'b000;
    last_d = hit ? win + 2'd1 : last_q;
  end
  // pointer moves only when a grant is issued
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 2'd3;
    else last_q <= last_d;
endmodule

// File: rtl/ingress_arbiter.sv
// ingress_arbiter: prefetches FIFO head words, drops dst 0, round-robins the rest onto three ports
module ingress_arbiter import switch_pkg::*; #(
  parameter int DST_MSB = DST_MSB_DEF,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  ingress_arbiter_if.master bus
);
  logic [WORD_W-1:0] q_in [3];
  in_state_t state_q [3];
  in_state_t state_d [3];
  logic [WORD_W-1:0] hold_q [3];
  logic [WORD_W-1:0] hold_d [3];
  logic [2:0] rdreq_q, rdreq_d;
  logic [2:0] valid_q, valid_d;
  logic [WORD_W-1:0] data_q [3];
  logic [WORD_W-1:0] data_d [3];
  port_idx_t sel_q [3];
  port_idx_t sel_d [3];
  port_idx_t gsel [3];
  port_idx_t dst [3];
  logic [2:0] req [3];
  logic [2:0] gnt [3];
  logic [2:0] en, granted, drop;
  logic [1:0] ndrop;
  logic [CNT_W:0] cnt_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign q_in[0] = bus.fifo_q1;
  assign q_in[1] = bus.fifo_q2;
  assign q_in[2] = bus.fifo_q3;
  assign granted = gnt[0] | gnt[1] | gnt[2];
  // decode held destinations; output j requests every held input whose dst is j+1
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dst[i] = hold_q[i][DST_MSB -: DST_W];
      drop[i] = state_q[i] == S_HELD && dst[i] == DST_DROP;
    end
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 3; i++)
        req[j][i] = state_q[i] == S_HELD && dst[i] == port_idx_t'(j + 1);
  end
  // a port may take a new word when its register is empty or draining this cycle
  for (genvar j = 0; j < 3; j++) begin : g_rr
    assign en[j] = ~valid_q[j] | bus.out_ready[j];
    rr_arbiter3 u_rr (
      .clk  (clk),
      .rst_n(reset),
      .req_i(req[j]),
      .en_i (en[j]),
      .gnt_o(gnt[j])
    );
  end
  // per-input fetch FSM: one outstanding read, hold register freed by grant or drop
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      hold_d[i] = hold_q[i];
      rdreq_d[i] = 1'b0;
      case (state_q[i])
        S_EMPTY: begin
          rdreq_d[i] = ~bus.fifo_empty[i];
          state_d[i] = bus.fifo_empty[i] ? S_EMPTY : S_REQ;
        end
        S_REQ: state_d[i] = S_WAIT;
        S_WAIT: begin
          state_d[i] = S_HELD;
          hold_d[i] = q_in[i];
        end
        default: state_d[i] = (granted[i] || drop[i]) ? S_EMPTY : S_HELD;
      endcase
    end
  end
  // output registers: a grant reloads, an accept without a grant clears
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      gsel[j] = oh_to_sel(gnt[j]);
      valid_d[j] = |gnt[j] | (valid_q[j] & ~bus.out_ready[j]);
      sel_d[j] = |gnt[j] ? gsel[j] : valid_d[j] ? sel_q[j] : 2'd0;
      data_d[j] = |gnt[j] ? hold_q[gsel[j] - 2'd1] : valid_d[j] ? data_q[j] : '0;
    end
  end
  // saturating drop counter; up to three drops can land on one edge
  always_comb begin
    ndrop = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
    cnt_sum = {1'b0, cnt_q} + {{(CNT_W - 1){1'b0}}, ndrop};
    cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end
  // state registers, cleared asynchronously so in-flight reads are discarded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdreq_q <= '0;
      valid_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= S_EMPTY;
        hold_q[i] <= '0;
        data_q[i] <= '0;
        sel_q[i] <= 2'd0;
      end
    end else begin
      rdreq_q <= rdreq_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i] <= hold_d[i];
        data_q[i] <= data_d[i];
        sel_q[i] <= sel_d[i];
      end
    end
  end
  assign bus.fifo_rdreq = rdreq_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data1 = data_q[0];
  assign bus.out_data2 = data_q[1];
  assign bus.out_data3 = data_q[2];
  assign bus.sel1 = sel_q[0];
  assign bus.sel2 = sel_q[1];
  assign bus.sel3 = sel_q[2];
  assign bus.drop_count = cnt_q;
endmodule

// File: tb/tb_ingress_arbiter.sv
// tb_ingress_arbiter: directed vectors and corner sequences for ingress_arbiter
module tb_ingress_arbiter;
  import switch_pkg::*;
  typedef struct packed {
    logic [2:0] mask;
    logic [2:0][31:0] w;
    logic [2:0] ev;
    logic [2:0][1:0] es;
    logic [15:0] drop;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int pass_cnt = 0;
  int total = 0;
  int rq2 = 0;
  logic [31:0] mem [3][64];
  int wr [3] = '{0, 0, 0};
  int rd [3] = '{0, 0, 0};
  logic [31:0] fq [3] = '{32'h0, 32'h0, 32'h0};
  vec_t vt [6];
  port_idx_t exp_b [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [31:0] exp_bd [7] = '{32'h8000_0010, 32'h8000_0011, 32'h8000_0012, 32'h0,
                              32'h8000_0020, 32'h8000_0021, 32'h8000_0022};
  always #5 clk = ~clk;
  ingress_arbiter_if #(.CNT_W(16)) bus();
  ingress_arbiter_if #(.CNT_W(2)) sbus();
  ingress_arbiter #(.DST_MSB(31), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  ingress_arbiter #(.DST_MSB(31), .CNT_W(2)) dut_sat (.clk(clk), .reset(reset), .bus(sbus));
  // normal-mode FIFO model: q updates at the edge that samples rdreq
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (bus.fifo_rdreq[i]) begin
        fq[i] <= mem[i][rd[i]];
        rd[i] <= rd[i] + 1;
      end
  assign bus.fifo_empty = {rd[2] == wr[2], rd[1] == wr[1], rd[0] == wr[0]};
  assign bus.fifo_q1 = fq[0];
  assign bus.fifo_q2 = fq[1];
  assign bus.fifo_q3 = fq[2];
  assign sbus.fifo_empty = 3'b110;
  assign sbus.fifo_q1 = 32'h0;
  assign sbus.fifo_q2 = 32'h0;
  assign sbus.fifo_q3 = 32'h0;
  assign sbus.out_ready = 3'b111;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (bus.fifo_rdreq[1]) rq2++;
    end
  endtask
  task automatic push(input int f, input logic [31:0] w);
    mem[f][wr[f]] = w;
    wr[f]++;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask
  function automatic logic [31:0] sel_of(input int j);
    return j == 0 ? 32'(bus.sel1) : j == 1 ? 32'(bus.sel2) : 32'(bus.sel3);
  endfunction
  function automatic logic [31:0] data_of(input int j);
    return j == 0 ? bus.out_data1 : j == 1 ? bus.out_data2 : bus.out_data3;
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{3'b001, {32'h0, 32'h0, 32'h4000_00AA}, 3'b001, {2'd0, 2'd0, 2'd1}, 16'd0};
    vt[1] = '{3'b111, {32'hC000_0003, 32'h8000_0002, 32'h4000_0001}, 3'b111, {2'd3, 2'd2, 2'd1}, 16'd0};
    vt[2] = '{3'b100, {32'h0000_1234, 32'h0, 32'h0}, 3'b000, {2'd0, 2'd0, 2'd0}, 16'd1};
    vt[3] = '{3'b010, {32'h0, 32'hC000_0055, 32'h0}, 3'b100, {2'd2, 2'd0, 2'd0}, 16'd1};
    vt[4] = '{3'b011, {32'h0, 32'h4000_0002, 32'h8000_0001}, 3'b011, {2'd0, 2'd1, 2'd2}, 16'd1};
    vt[5] = '{3'b101, {32'h3FFF_FFFF, 32'h0, 32'h0000_0000}, 3'b000, {2'd0, 2'd0, 2'd0}, 16'd3};
    bus.out_ready = 3'b000;
    tick(2);
    chk("rst_rdreq", 32'(bus.fifo_rdreq), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_sel1", 32'(bus.sel1), 32'h0);
    chk("rst_data1", bus.out_data1, 32'h0);
    chk("rst_drop", 32'(bus.drop_count), 32'h0);
    reset = 1'b1;
    bus.out_ready = 3'b111;
    for (int v = 0; v < 6; v++) begin
      for (int f = 0; f < 3; f++) if (vt[v].mask[f]) push(f, vt[v].w[f]);
      tick(1);
      chk($sformatf("v%0d_rdreq", v), 32'(bus.fifo_rdreq), 32'(vt[v].mask));
      tick(2);
      chk($sformatf("v%0d_early", v), 32'(bus.out_valid), 32'h0);
      tick(1);
      chk($sformatf("v%0d_valid", v), 32'(bus.out_valid), 32'(vt[v].ev));
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("v%0d_sel%0d", v, j + 1), sel_of(j), 32'(vt[v].es[j]));
        if (vt[v].ev[j]) chk($sformatf("v%0d_data%0d", v, j + 1), data_of(j), vt[v].w[vt[v].es[j] - 2'd1]);
      end
      chk($sformatf("v%0d_drop", v), 32'(bus.drop_count), 32'(vt[v].drop));
      tick(2);
      chk($sformatf("v%0d_drain", v), 32'(bus.out_valid), 32'h0);
    end
    bus.out_ready = 3'b000;
    push(0, 32'h4000_0111);
    tick(4);
    chk("mid_pre_valid", 32'(bus.out_valid), 32'h1);
    push(1, 32'h8000_BEEF);
    push(1, 32'h8000_0002);
    tick(1);
    chk("mid_rdreq", 32'(bus.fifo_rdreq), 32'h2);
    tick(1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_data1", bus.out_data1, 32'h0);
    chk("mid_rst_sel1", 32'(bus.sel1), 32'h0);
    chk("mid_rst_drop", 32'(bus.drop_count), 32'h0);
    tick(2);
    reset = 1'b1;
    bus.out_ready = 3'b111;
    tick(4);
    chk("mid_post_valid", 32'(bus.out_valid), 32'h2);
    chk("mid_post_data2", bus.out_data2, 32'h8000_0002);
    chk("mid_post_sel2", 32'(bus.sel2), 32'h2);
    tick(1);
    chk("mid_post_drop", 32'(bus.drop_count), 32'h0);
    tick(3);
    chk("mid_post_idle", 32'(bus.out_valid), 32'h0);
    do_reset();
    for (int f = 0; f < 3; f++) begin
      push(f, 32'h8000_0010 + 32'(f));
      push(f, 32'h8000_0020 + 32'(f));
    end
    tick(3);
    for (int c = 0; c < 7; c++) begin
      tick(1);
      chk($sformatf("rr_sel2_c%0d", c), 32'(bus.sel2), 32'(exp_b[c]));
      if (exp_b[c] != 2'd0) chk($sformatf("rr_data2_c%0d", c), bus.out_data2, exp_bd[c]);
    end
    tick(3);
    chk("rr_idle", 32'(bus.out_valid), 32'h0);
    do_reset();
    bus.out_ready = 3'b011;
    rq2 = 0;
    push(1, 32'hC000_0001);
    push(1, 32'hC000_0002);
    push(1, 32'hC000_0003);
    tick(4);
    chk("stall_valid0", 32'(bus.out_valid), 32'h4);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk($sformatf("stall_v%0d", k), 32'(bus.out_valid[2]), 32'h1);
      chk($sformatf("stall_d%0d", k), bus.out_data3, 32'hC000_0001);
      chk($sformatf("stall_s%0d", k), 32'(bus.sel3), 32'h2);
    end
    chk("stall_reads", 32'(rq2), 32'h2);
    bus.out_ready = 3'b111;
    tick(1);
    chk("reload_valid", 32'(bus.out_valid[2]), 32'h1);
    chk("reload_data3", bus.out_data3, 32'hC000_0002);
    tick(1);
    chk("reload_drain", 32'(bus.out_valid[2]), 32'h0);
    tick(6);
    chk("stall_reads_end", 32'(rq2), 32'h3);
    do_reset();
    tick(4);
    chk("sat_1", 32'(sbus.drop_count), 32'h1);
    tick(8);
    chk("sat_3", 32'(sbus.drop_count), 32'h3);
    tick(8);
    chk("sat_hold", 32'(sbus.drop_count), 32'h3);
    chk("sat_no_valid", 32'(sbus.out_valid), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/ingress_arbiter.md
# ingress_arbiter

Ingress arbitration stage of the 3-port packet switch. It sits directly downstream of the three ingress FIFOs that the Avalon write path fills. It prefetches the head word of each FIFO into a one-entry hold register and decodes the word's destination field. A per-output round-robin arbiter then forwards each word to one of three output ports, with a valid/ready handshake toward the output buffer stage.

## Interface
Parameters:
- DST_MSB, default 31: upper bit of the 2-bit destination field in each 32-bit word.
- CNT_W, default 16: width of the drop counter.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low reset. Asserted (0) clears all state immediately.
- fifo_empty  in  3  bit i = empty flag of ingress FIFO i+1.
- fifo_q1, fifo_q2, fifo_q3  in  32 each  FIFO output words. Normal (non-show-ahead) mode: q updates at the clock edge that samples rdreq.
- fifo_rdreq  out  3  bit i = one-cycle read pulse to FIFO i+1. Registered.
- out_ready  in  3  bit j = output port j+1 can accept a word this cycle.
- out_valid  out  3  bit j = out_data(j+1) and sel(j+1) are valid this cycle.
- out_data1, out_data2, out_data3  out  32 each  forwarded word.
- sel1, sel2, sel3  out  2 each  source FIFO of the forwarded word (1..3). 0 when not valid, matching the mux convention where input 0 is the zero word.
- drop_count  out  CNT_W  saturating count of words discarded with destination 0.

## Operation
- Destination field: dst = word[DST_MSB:DST_MSB-1]. Values 1..3 mean output port 1..3; 0 means drop.
- Each input runs its own FSM with states EMPTY, REQ, WAIT, HELD.
  - EMPTY → REQ when fifo_empty[i]=0. The transition registers fifo_rdreq[i]=1 for exactly one cycle.
  - REQ → WAIT on the next edge; the FIFO advances at this edge.
  - WAIT → HELD: capture fifo_q into the hold register, set hold_valid.
  - HELD → EMPTY when the word is granted or dropped.
- At most one rdreq is outstanding per input. A new read is never issued while the input is in REQ, WAIT or HELD, so a stale empty flag cannot cause underflow.
- Drop: a HELD word with dst=0 is cleared on the next edge, with no output. drop_count increments and saturates at all-ones.
- Arbitration: output j considers the HELD inputs with dst=j.
  - It is eligible only if the output register for port j is empty, or is emptying this cycle (out_valid[j] && out_ready[j]).
  - Round-robin: priority starts at the input after the last one granted. The pointer updates only on a grant.
  - An input targets exactly one output, so the three arbiters never contend for the same input.
- Output handshake:
  - A grant loads out_dataj and selj and sets out_valid[j]; the granted hold register is cleared at the same edge.
  - out_valid[j] stays high with the word stable until out_valid[j] && out_ready[j] at an edge.
  - selj = 0 whenever out_valid[j] = 0.

## Timing
- Reset values: fifo_rdreq=0, out_valid=0, out_data*=0, sel*=0, drop_count=0, every input FSM=EMPTY, every RR pointer=3 (so input 1 has first priority).
- Latency: fifo_empty[i] falls in cycle N → rdreq high in N+1 → q valid in N+2 → HELD in N+3 → out_valid high in N+4 at the earliest.
- Throughput: at most one word per input every 4 cycles. Back-to-back out_valid on one port is allowed when ready stays high and a new word is held.
- Simultaneous events:
  - A grant and a downstream accept on the same port at the same edge are legal; the port reloads with no bubble.
  - A drop and a grant on different inputs at the same edge are independent.
- Reset asserted mid-operation: all state clears asynchronously. A word already popped from a FIFO (in REQ or WAIT) is discarded and not counted.

## Structure
- Shared package switch_pkg holds:
  - port_idx_t (logic [1:0]).
  - DST_DROP = 2'd0.
  - The input FSM state enum.
  - Field-position constants, shared with the Avalon write path and the output buffer.
- Sub-module rr_arbiter3: 3-request round-robin arbiter with a grant-enable input and a one-hot grant output. Instantiated once per output port.

## Test plan
- Single word 0x4000_00AA in FIFO1 (dst=1), out_ready=3'b111 → rdreq[0] pulses once; out_valid[0] rises 4 cycles after empty falls; out_data1=0x4000_00AA, sel1=1.
- Words with dst=2 in all three FIFOs at the same time, out_ready[1]=1 → port 2 delivers them in order FIFO1, FIFO2, FIFO3, with sel2 = 1, 2, 3. A second round starts again at FIFO1.
- Word with dst=0 in FIFO3 → no out_valid anywhere; drop_count goes from 0 to 1. Preload drop_count to 0xFFFF and drop again → it stays 0xFFFF.
- out_ready[2]=0 while a dst=3 word is granted → out_valid[2], out_data3 and sel3 stay stable for 10 cycles. FIFO2 does not read a further word until its hold register clears. Raise ready → the word is accepted at the next edge.
- Words with dst=1, 2, 3 in FIFO1, FIFO2, FIFO3 respectively → all three out_valid bits rise in the same cycle with sel1=1, sel2=2, sel3=3.
- Assert reset in the cycle after rdreq[1] → all outputs read 0 immediately. After release, FIFO2's next word is fetched normally; the popped word never appears and is not counted.
